hub75_row_driver: RTL

- Parametrised HUB75 LED-panel scan driver.
- Fetches pixel pairs (upper/lower half) from an external frame memory with 1-cycle read latency, and shifts them out on SCLK.
- Latches each row, drives the row address, and holds the row lit for a programmable time.
- Sits between the frame buffer and the panel connector pins; replaces the earlier fixed 64-column shifter.

---
 rtl/hub75_row_driver.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hub75_row_driver.sv
// hub75_row_driver: HUB75 LED-panel scan driver.
// Reads one pixel pair per column from an external frame memory with one cycle
// of read latency, shifts the row out on SCLK, latches it, drives the row
// address and keeps the row lit for ON_CYCLES clocks.
// Optional build macro: TEST_PATTERN_EN replaces frame-memory data with an
// internal column/row pattern and keeps rd_en low; all timing is unchanged.
module hub75_row_driver #(
   parameter int COLS         = 64,
   parameter int ADDR_BITS    = 5,
   parameter int CLK_DIV      = 2,
   parameter int LATCH_CYCLES = 2,
   parameter int ON_CYCLES    = 256,
   localparam int COL_W       = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   output logic                       rd_en,
   output logic [ADDR_BITS+COL_W-1:0] rd_addr,
   input  logic [5:0]                 rd_data,
   output logic                       R0,
   output logic                       G0,
   output logic                       B0,
   output logic                       R1,
   output logic                       G1,
   output logic                       B1,
   output logic [ADDR_BITS-1:0]       A,
   output logic                       SCLK,
   output logic                       LATCH,
   output logic                       BLANK,
   output logic                       frame_done
);

   localparam int CNT_M1  = 2 * CLK_DIV;
   localparam int CNT_M2  = (LATCH_CYCLES > CNT_M1) ? LATCH_CYCLES : CNT_M1;
   localparam int CNT_MAX = (ON_CYCLES > CNT_M2) ? ON_CYCLES : CNT_M2;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * CLK_DIV);
   localparam logic [CNT_W-1:0] SCLK_RISE  = CNT_W'(CLK_DIV);
   localparam logic [CNT_W-1:0] DATA_PHASE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
   localparam logic [COL_W-1:0] COL_ZERO   = '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH,
      ST_DISPLAY
   } state_e;

   state_e                     state_q, state_d;
   logic [ADDR_BITS-1:0]       row_q, row_d;
   logic [COL_W-1:0]           col_q, col_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [5:0]                 colour_q, colour_d;
   logic [ADDR_BITS-1:0]       rowAddr_q, rowAddr_d;
   logic [ADDR_BITS+COL_W-1:0] rdAddr_q, rdAddr_d;
   logic                       rdEn_q, rdEn_d;
   logic                       sclk_q, sclk_d;
   logic                       latch_q, latch_d;
   logic                       blank_q, blank_d;
   logic                       frameDone_q, frameDone_d;

   logic [5:0]                 pixel;
   logic                       rdStrobe;

`ifdef TEST_PATTERN_EN
   logic unused_rd_data;
   assign unused_rd_data = ^rd_data;
   assign pixel    = {~col_q[0], row_q[0], 1'b0, ~col_q[0], row_q[0], 1'b0};
   assign rdStrobe = 1'b0;
`else
   assign pixel    = rd_data;
   assign rdStrobe = 1'b1;
`endif

   // Next-state and next-output logic; every output is registered, so each
   // branch computes what the pins must show during the following cycle.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      cnt_d       = cnt_q;
      colour_d    = colour_q;
      rowAddr_d   = rowAddr_q;
      rdAddr_d    = rdAddr_q;
      rdEn_d      = 1'b0;
      sclk_d      = 1'b0;
      latch_d     = 1'b0;
      blank_d     = 1'b1;
      frameDone_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d  = ST_SHIFT;
               cnt_d    = '0;
               col_d    = '0;
               rdEn_d   = rdStrobe;
               rdAddr_d = {row_q, COL_ZERO};
            end
         end

         ST_SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               cnt_d = '0;
               if (col_q == COL_LAST) begin
                  col_d     = '0;
                  state_d   = ST_LATCH;
                  latch_d   = 1'b1;
                  rowAddr_d = row_q;
               end else begin
                  col_d    = col_q + 1'b1;
                  rdEn_d   = rdStrobe;
                  rdAddr_d = {row_q, col_q + 1'b1};
               end
            end else begin
               cnt_d  = cnt_q + 1'b1;
               sclk_d = (cnt_q >= SCLK_RISE);
               if (cnt_q == DATA_PHASE) begin
                  colour_d = pixel;
               end
            end
         end

         ST_LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               cnt_d   = '0;
               state_d = ST_DISPLAY;
               blank_d = 1'b0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               latch_d = 1'b1;
            end
         end

         ST_DISPLAY: begin
            if (cnt_q == ON_LAST) begin
               cnt_d       = '0;
               col_d       = '0;
               row_d       = row_q + 1'b1;
               frameDone_d = (row_q == {ADDR_BITS{1'b1}});
               if (enable) begin
                  state_d  = ST_SHIFT;
                  rdEn_d   = rdStrobe;
                  rdAddr_d = {row_q + 1'b1, COL_ZERO};
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d   = cnt_q + 1'b1;
               blank_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset to the dark, idle panel.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         cnt_q       <= '0;
         colour_q    <= '0;
         rowAddr_q   <= '0;
         rdAddr_q    <= '0;
         rdEn_q      <= 1'b0;
         sclk_q      <= 1'b0;
         latch_q     <= 1'b0;
         blank_q     <= 1'b1;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cnt_q       <= cnt_d;
         colour_q    <= colour_d;
         rowAddr_q   <= rowAddr_d;
         rdAddr_q    <= rdAddr_d;
         rdEn_q      <= rdEn_d;
         sclk_q      <= sclk_d;
         latch_q     <= latch_d;
         blank_q     <= blank_d;
         frameDone_q <= frameDone_d;
      end
   end

   assign {R0, G0, B0, R1, G1, B1} = colour_q;
   assign A          = rowAddr_q;
   assign rd_en      = rdEn_q;
   assign rd_addr    = rdAddr_q;
   assign SCLK       = sclk_q;
   assign LATCH      = latch_q;
   assign BLANK      = blank_q;
   assign frame_done = frameDone_q;

endmodule
